lfsr_sched: RTL

Shared-LFSR scheduler: owns one WIDTH-bit shift-left LFSR engine and time-multiplexes it between NREQ requesters. Each requester supplies a seed and a step count. The block arbitrates round-robin, loads the seed and clocks the LFSR the requested number of times. It then returns the final state with a one-cycle done pulse tagged with the requester id. It sits between the pattern-generation users and the LFSR datapath; no requester drives the LFSR directly.

---
 rtl/lfsr_sched.sv | 108 ++++++++++
 1 files changed

// File: rtl/lfsr_sched.sv
// Shared-LFSR scheduler: a round-robin arbiter that lends one shift-left LFSR engine to NREQ
// requesters, runs each granted job for its step count and returns the final state.
module lfsr_sched #(
    parameter int unsigned     WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS = 4'b1100,
    parameter int unsigned     NREQ  = 2,
    parameter int unsigned     CNTW  = 8,
    parameter int unsigned     IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*WIDTH-1:0] seed,
    input  logic [NREQ*CNTW-1:0] steps,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic                 done,
    output logic [IDW-1:0]       done_id,
    output logic [WIDTH-1:0]     result
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] lfsr_q;
    logic [CNTW-1:0]  cnt_q;
    logic [IDW-1:0]   last_q;

    logic             pick_found;
    logic [IDW-1:0]   pick_id;
    logic [NREQ-1:0]  pick_onehot;
    logic [WIDTH-1:0] seed_sel;
    logic [WIDTH-1:0] seed_fixed;
    logic [CNTW-1:0]  steps_sel;
    logic [WIDTH-1:0] lfsr_next;

    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int unsigned k);
        int unsigned idx;
        idx = (32'(base) + 32'd1 + k) % NREQ;
        return idx[IDW-1:0];
    endfunction

    // First requesting index at or after last+1, wrapping, so nobody starves.
    always_comb begin
        pick_found  = 1'b0;
        pick_id     = '0;
        pick_onehot = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!pick_found && req[rr_index(last_q, k)]) begin
                pick_found = 1'b1;
                pick_id    = rr_index(last_q, k);
            end
        end
        pick_onehot[pick_id] = 1'b1;
        seed_sel   = seed[pick_id*WIDTH +: WIDTH];
        steps_sel  = steps[pick_id*CNTW +: CNTW];
        // All-zero is the lockup state; substitute 1 so the engine always advances.
        seed_fixed = (seed_sel == '0) ? WIDTH'(1) : seed_sel;
        lfsr_next  = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            gnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= '0;
            result  <= '0;
            lfsr_q  <= '0;
            cnt_q   <= '0;
            last_q  <= IDW'(NREQ - 1);
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (pick_found) begin
                        gnt     <= pick_onehot;
                        busy    <= 1'b1;
                        last_q  <= pick_id;
                        lfsr_q  <= seed_fixed;
                        cnt_q   <= steps_sel;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (cnt_q == '0) begin
                        result  <= lfsr_q;
                        done_id <= last_q;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        lfsr_q <= lfsr_next;
                        cnt_q  <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    gnt     <= '0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
